// File: rtl/seq_det_pkg.sv
// Shared defaults, mode encodings and state type for the parameterised sequence detector.
package seq_det_pkg;

  localparam int          DEF_PAT_LEN   = 4;
  localparam logic [3:0]  DEF_RESET_PAT = 4'b1011;
  localparam int          DEF_CNT_W     = 8;

  localparam int MODE_MOORE  = 0;
  localparam int MODE_MEALY  = 1;
  localparam int OVERLAP_OFF = 0;
  localparam int OVERLAP_ON  = 1;

  typedef enum logic {
    FILLING = 1'b0,
    ARMED   = 1'b1
  } fill_state_e;

endpackage

// File: rtl/seq_detector_param_if.sv
// Serial stream, pattern control and match reporting signals of the sequence detector.
interface seq_detector_param_if
  import seq_det_pkg::*;
#(
  parameter int PAT_LEN = DEF_PAT_LEN,
  parameter int CNT_W   = DEF_CNT_W
);
  logic               sequence_valid;
  logic               sequence_in;
  logic               pattern_load;
  logic [PAT_LEN-1:0] pattern;
  logic               count_clear;
  logic               detector_out;
  logic [CNT_W-1:0]   match_count;
  logic               count_sat;

  modport master (
    output sequence_valid, sequence_in, pattern_load, pattern, count_clear,
    input  detector_out, match_count, count_sat
  );

  modport slave (
    input  sequence_valid, sequence_in, pattern_load, pattern, count_clear,
    output detector_out, match_count, count_sat
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky saturation flag; clear wins over increment but keeps it.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         sat
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      count <= inc ? W'(1) : '0;
      sat   <= 1'b0;
    end else if (inc) begin
      if (&count) begin
        sat <= 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with loadable pattern, Moore/Mealy output timing,
// optional overlap and a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN   = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] RESET_PAT = PAT_LEN'(DEF_RESET_PAT),
  parameter int                 MEALY     = MODE_MOORE,
  parameter int                 OVERLAP   = OVERLAP_ON,
  parameter int                 CNT_W     = DEF_CNT_W
) (
  input  logic                clock,
  input  logic                reset,
  seq_detector_param_if.slave bus
);

  localparam int             FW         = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0]  FULL       = FW'(PAT_LEN);
  localparam bit             IS_MEALY   = (MEALY == MODE_MEALY);
  localparam bit             NO_OVERLAP = (OVERLAP == OVERLAP_OFF);

  logic [PAT_LEN-1:0] pat_q;
  logic [PAT_LEN-1:0] hist_q;
  logic [PAT_LEN-1:0] cand;
  logic [FW-1:0]      fill_q;
  logic [FW-1:0]      cand_fill;
  fill_state_e        state;
  logic               match;
  logic               det_q;
  logic [CNT_W-1:0]   count;
  logic               sat;
  logic               unused_hist_msb;

  // The oldest history bit shifts out and never takes part in a comparison.
  assign unused_hist_msb = hist_q[PAT_LEN-1];

  assign state     = (fill_q == FULL) ? ARMED : FILLING;
  assign cand      = {hist_q[PAT_LEN-2:0], bus.sequence_in};
  assign cand_fill = (state == ARMED) ? FULL : fill_q + 1'b1;
  assign match     = bus.sequence_valid & ~bus.pattern_load
                   & (cand_fill == FULL) & (cand == pat_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      pat_q  <= RESET_PAT;
      hist_q <= '0;
      fill_q <= '0;
      det_q  <= 1'b0;
    end else if (bus.pattern_load) begin
      pat_q  <= bus.pattern;
      hist_q <= '0;
      fill_q <= '0;
      det_q  <= 1'b0;
    end else begin
      det_q <= match;
      if (bus.sequence_valid) begin
        hist_q <= cand;
        fill_q <= (match && NO_OVERLAP) ? '0 : cand_fill;
      end
    end
  end

  assign bus.detector_out = IS_MEALY ? (match & ~reset) : det_q;

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (match),
    .clr   (bus.count_clear),
    .count (count),
    .sat   (sat)
  );

  assign bus.match_count = count;
  assign bus.count_sat   = sat;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param across default, non-overlap, Mealy and narrow-counter builds.
module tb_seq_detector_param;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  int         sel   = 0;
  logic       v     = 1'b0;
  logic       b     = 1'b0;
  logic       ld    = 1'b0;
  logic       clr   = 1'b0;
  logic [3:0] pat   = 4'b0000;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  typedef struct {
    string tag;
    logic  expv;
  } exp_t;
  exp_t sb_q[$];

  always #5 clock = ~clock;

  seq_detector_param_if #(.PAT_LEN(4), .CNT_W(8)) if_def ();
  seq_detector_param_if #(.PAT_LEN(4), .CNT_W(8)) if_nov ();
  seq_detector_param_if #(.PAT_LEN(4), .CNT_W(8)) if_mly ();
  seq_detector_param_if #(.PAT_LEN(4), .CNT_W(2)) if_sat ();

  assign if_def.sequence_valid = v & (sel == 0);
  assign if_nov.sequence_valid = v & (sel == 1);
  assign if_mly.sequence_valid = v & (sel == 2);
  assign if_sat.sequence_valid = v & (sel == 3);
  assign if_def.pattern_load   = ld & (sel == 0);
  assign if_nov.pattern_load   = ld & (sel == 1);
  assign if_mly.pattern_load   = ld & (sel == 2);
  assign if_sat.pattern_load   = ld & (sel == 3);
  assign if_def.count_clear    = clr & (sel == 0);
  assign if_nov.count_clear    = clr & (sel == 1);
  assign if_mly.count_clear    = clr & (sel == 2);
  assign if_sat.count_clear    = clr & (sel == 3);
  assign if_def.sequence_in    = b;
  assign if_nov.sequence_in    = b;
  assign if_mly.sequence_in    = b;
  assign if_sat.sequence_in    = b;
  assign if_def.pattern        = pat;
  assign if_nov.pattern        = pat;
  assign if_mly.pattern        = pat;
  assign if_sat.pattern        = pat;

  seq_detector_param u_def (.clock(clock), .reset(reset), .bus(if_def.slave));
  seq_detector_param #(.OVERLAP(0)) u_nov (.clock(clock), .reset(reset), .bus(if_nov.slave));
  seq_detector_param #(.MEALY(1))   u_mly (.clock(clock), .reset(reset), .bus(if_mly.slave));
  seq_detector_param #(.CNT_W(2))   u_sat (.clock(clock), .reset(reset), .bus(if_sat.slave));

  logic [3:0] det_all;
  assign det_all = {if_sat.detector_out, if_mly.detector_out, if_nov.detector_out, if_def.detector_out};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drives one cycle of stimulus, queues its expected output and compares it when it is due:
  // before the edge for the Mealy build, one edge later for the Moore builds.
  task automatic step(input string tag, input logic vi, input logic bi, input logic ldi,
                      input logic clri, input logic [3:0] pati, input logic expd);
    exp_t e;
    v   = vi;
    b   = bi;
    ld  = ldi;
    clr = clri;
    pat = pati;
    sb_q.push_back('{tag, expd});
    if (sel == 2) begin
      #2;
      e = sb_q.pop_front();
      check(e.tag, 32'(det_all[sel]), 32'(e.expv));
      @(posedge clock);
      #1;
    end else begin
      @(posedge clock);
      #1;
      e = sb_q.pop_front();
      check(e.tag, 32'(det_all[sel]), 32'(e.expv));
    end
    v   = 1'b0;
    ld  = 1'b0;
    clr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [6:0]  s7;
    logic [6:0]  e7;
    logic [15:0] s16;
    logic [15:0] e16;

    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_def_det", 32'(if_def.detector_out), 0);
    check("rst_def_cnt", 32'(if_def.match_count), 0);
    check("rst_def_fill", 32'(u_def.fill_q), 0);
    check("rst_sat_flag", 32'(if_sat.count_sat), 0);

    // Default build: overlapping matches after bits 4 and 7
    sel = 0;
    s7 = 7'b1011011;
    e7 = 7'b0001001;
    for (int i = 0; i < 7; i++) step($sformatf("def_bit%0d", i + 1), 1'b1, s7[6-i], 1'b0, 1'b0, 4'b0, e7[6-i]);
    check("def_count", 32'(if_def.match_count), 2);

    // Non-overlapping build: a single match
    sel = 1;
    e7 = 7'b0001000;
    for (int i = 0; i < 7; i++) step($sformatf("nov_bit%0d", i + 1), 1'b1, s7[6-i], 1'b0, 1'b0, 4'b0, e7[6-i]);
    check("nov_count", 32'(if_nov.match_count), 1);

    // Mealy build: pulse in the same cycle as bit 4, nothing after
    sel = 2;
    step("mly_bit1", 1'b1, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0);
    step("mly_bit2", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
    step("mly_bit3", 1'b1, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0);
    step("mly_bit4", 1'b1, 1'b1, 1'b0, 1'b0, 4'b0, 1'b1);
    step("mly_after", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
    check("mly_count", 32'(if_mly.match_count), 1);

    // Mealy output stays low while reset is high, even on a would-be match
    step("mly_pre0", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
    step("mly_pre1", 1'b1, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0);
    reset = 1'b1;
    step("mly_in_rst", 1'b1, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0);
    reset = 1'b0;
    check("mly_rst_count", 32'(if_mly.match_count), 0);
    check("def_rst_count", 32'(if_def.match_count), 0);

    // Pattern load discards the bit presented in the same cycle
    sel = 0;
    step("ld_cycle", 1'b1, 1'b1, 1'b1, 1'b0, 4'b0110, 1'b0);
    check("ld_fill", 32'(u_def.fill_q), 0);
    step("ld_bit1", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
    check("ld_fill1", 32'(u_def.fill_q), 1);
    step("ld_bit2", 1'b1, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0);
    step("ld_bit3", 1'b1, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0);
    step("ld_bit4", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 1'b1);
    check("ld_count", 32'(if_def.match_count), 1);

    // Narrow counter: five matches saturate at 3
    sel = 3;
    s16 = 16'b1011011011011011;
    e16 = 16'b0001001001001001;
    for (int i = 0; i < 16; i++) step($sformatf("sat_bit%0d", i + 1), 1'b1, s16[15-i], 1'b0, 1'b0, 4'b0, e16[15-i]);
    check("sat_count", 32'(if_sat.match_count), 3);
    check("sat_flag", 32'(if_sat.count_sat), 1);
    step("sat_clr", 1'b0, 1'b0, 1'b0, 1'b1, 4'b0, 1'b0);
    check("clr_count", 32'(if_sat.match_count), 0);
    check("clr_flag", 32'(if_sat.count_sat), 0);
    step("clrm_bit1", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
    step("clrm_bit2", 1'b1, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0);
    step("clrm_bit3", 1'b1, 1'b1, 1'b0, 1'b1, 4'b0, 1'b1);
    check("clrm_count", 32'(if_sat.match_count), 1);
    check("clrm_flag", 32'(if_sat.count_sat), 0);

    // Reset in the middle of a partial match
    sel = 0;
    do_reset();
    step("mid_bit1", 1'b1, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0);
    step("mid_bit2", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
    step("mid_bit3", 1'b1, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0);
    do_reset();
    step("mid_after", 1'b1, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0);
    check("mid_fill", 32'(u_def.fill_q), 1);
    check("mid_count", 32'(if_def.match_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
